uart_tx_stream: RTL
===================

UART_TX_STREAM -- requirements
Module: uart_tx_stream

Interface
REQ-001 SHALL provide parameter CLK_FRE, default 50, system clock frequency in MHz.
REQ-002 SHALL provide parameter BAUD_RATE, default 9600, line bit rate.
REQ-003 SHALL provide parameter DATA_WIDTH, default 8, data bits per frame, legal 5..9.
REQ-004 SHALL provide parameter PARITY_MODE, default 0, encoded as: 0 none, 1 even, 2 odd, 3 mark (1), 4 space (0).
REQ-005 SHALL provide parameter STOP_BITS, default 1, legal 1 or 2.
REQ-006 SHALL provide parameter FIFO_DEPTH, default 16, power of two, 2..256.
REQ-007 SHALL provide port i_clk_sys, input, 1 bit, system clock, all logic on rising edge.
REQ-008 SHALL provide port i_rst_n, input, 1 bit, reset, asynchronous, active-low.
REQ-009 SHALL provide port i_data_tx, input, DATA_WIDTH bits, word to send, LSB transmitted first.
REQ-010 SHALL provide port i_data_valid, input, 1 bit, word on i_data_tx is offered.
REQ-011 SHALL provide port o_data_ready, output, 1 bit, block accepts a word this cycle.
REQ-012 SHALL provide port o_uart_tx_data, output, 1 bit, serial line, idle high.
REQ-013 SHALL provide port o_uart_tx_busy, output, 1 bit, high while the FSM is not IDLE.
REQ-014 SHALL provide port o_uart_tx_end, output, 1 bit, one-cycle pulse when the last stop bit period completes.
REQ-015 SHALL provide port o_fifo_level, output, $clog2(FIFO_DEPTH)+1 bits, count of words buffered and not yet loaded.

Function
REQ-016 Bit period SHALL be CYCLE = CLK_FRE*1000000/BAUD_RATE clocks (integer division), counted by a baud counter running 0..CYCLE-1 and reset to 0 on every state change.
REQ-017 A word SHALL be accepted on a rising edge where i_data_valid && o_data_ready; o_data_ready SHALL equal !full.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, and each non-IDLE state SHALL drive the line for whole bit periods: START 0, DATA shift-register LSB, PARITY computed bit, STOP 1.
REQ-019 IDLE SHALL move to START, loading the head word and popping it, on the first edge where the FIFO is non-empty.
REQ-020 START SHALL move to DATA after 1 period.
REQ-021 DATA SHALL move to PARITY after DATA_WIDTH periods, or directly to STOP when PARITY_MODE==0.
REQ-022 PARITY SHALL move to STOP after 1 period.
REQ-023 STOP SHALL last STOP_BITS periods, then go to START if the FIFO is non-empty (no idle gap), else to IDLE.
REQ-024 Latency: a word accepted at edge N into an empty FIFO with the FSM in IDLE SHALL produce the start-bit falling edge on the line at edge N+2.
REQ-025 Even parity SHALL be the XOR of the data bits; odd parity SHALL be its inverse; mark SHALL be 1; space SHALL be 0.
REQ-026 o_uart_tx_end SHALL pulse for exactly one clock, registered, on the edge the final stop period ends.
REQ-027 A simultaneous push and pop SHALL leave o_fifo_level unchanged and be legal when full or empty.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 i_data_tx SHALL be sampled only at acceptance; later changes SHALL have no effect on queued frames.

Reset
REQ-030 While i_rst_n is low, outputs SHALL be: o_uart_tx_data=1, o_uart_tx_busy=0, o_uart_tx_end=0, o_fifo_level=0, o_data_ready=0.
REQ-031 After reset release, o_data_ready SHALL go 1 on the first edge.
REQ-032 Reset mid-frame SHALL abort the frame immediately (line high) and discard all FIFO contents.

Configuration
REQ-033 With macro UART_TX_STREAM_FIFO_EN defined, the FIFO SHALL be FIFO_DEPTH deep.
REQ-034 Without UART_TX_STREAM_FIFO_EN, the buffer SHALL be a single holding register: FIFO_DEPTH ignored, o_fifo_level 0/1, o_data_ready=!holding_full, all other timing identical.

Structure
REQ-035 Package uart_pkg SHALL hold the FSM state typedef, the parity-mode constants, and the CYCLE calculation function.
REQ-036 The buffer SHALL be sub-module uart_tx_fifo (sync FIFO, level output); the FSM, baud counter and shifter SHALL live in uart_tx_stream.

Verification (CLK_FRE=1, BAUD_RATE=100000 -> CYCLE=10)
REQ-037 Push 0xA5, 8N1 -> line: 0 for 10 clocks starting at N+2, then bits 1,0,1,0,0,1,0,1, then 1; end pulse once at clock N+101.
REQ-038 PARITY_MODE=1 and PARITY_MODE=2, push 0x07 -> parity bit 1 (even) and 0 (odd); STOP_BITS=2 -> stop high 20 clocks.
REQ-039 Push 3 words back-to-back -> frames contiguous, no idle clocks, 3 end pulses, busy high throughout.
REQ-040 Hold valid with FIFO_EN, DEPTH=4 -> ready drops after 5 accepts (4 buffered + 1 loaded), recovers on the next load; push and pop on the same edge leaves level at 4.
REQ-041 Assert reset mid-DATA -> line 1 in the same cycle, level 0, no end pulse, next frame correct.
REQ-042 Build without FIFO_EN -> second word stalls (ready=0) until the first frame loads.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and helpers for the UART transmit stream
//
// Holds the transmit FSM state type, the parity-mode encoding used by the
// PARITY_MODE parameter, and the bit-period calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int PAR_NONE  = 0;
    localparam int PAR_EVEN  = 1;
    localparam int PAR_ODD   = 2;
    localparam int PAR_MARK  = 3;
    localparam int PAR_SPACE = 4;

    // Clocks per bit period; clk_fre is in MHz, result truncates.
    function automatic int calc_cycle(input int clk_fre, input int baud_rate);
        return (clk_fre * 1000000) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - word buffer between the stream input and the serialiser
//
// Synchronous FIFO with occupancy output. With UART_TX_STREAM_FIFO_EN defined
// it is FIFO_DEPTH words deep; otherwise it collapses to a single holding
// register (level 0/1) and FIFO_DEPTH only sizes the level port.
//
// Ports:
//   i_clk_sys, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_data       write strobe and word
//   i_pop                consume the head word
//   o_data               head word
//   o_empty, o_full      occupancy flags
//   o_level              words currently stored
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          i_clk_sys,
    input  logic                          i_rst_n,
    input  logic                          i_push,
    input  logic [DATA_WIDTH-1:0]         i_data,
    input  logic                          i_pop,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_empty,
    output logic                          o_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic push_ok;
    logic pop_ok;

`ifdef UART_TX_STREAM_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = FIFO_DEPTH[LVL_W-1:0];

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;

    assign o_empty = (level_q == '0);
    assign o_full  = (level_q == FULL_LVL);
    // A write while full is allowed when the head leaves on the same edge.
    assign push_ok = i_push && (!o_full || i_pop);
    assign pop_ok  = i_pop && !o_empty;
    assign o_data  = mem_q[rd_ptr_q];
    assign o_level = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // Power-of-two depth: pointers wrap by natural overflow.
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop_ok) level_d = level_q + LVL_W'(1);
        else if (!push_ok && pop_ok) level_d = level_q - LVL_W'(1);
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: contents are only visible through level_q.
    always_ff @(posedge i_clk_sys) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_data;
    end
`else
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  full_q, full_d;

    assign o_empty = !full_q;
    assign o_full  = full_q;
    assign push_ok = i_push && (!full_q || i_pop);
    assign pop_ok  = i_pop && full_q;
    assign o_data  = hold_q;
    assign o_level = LVL_W'(full_q);

    always_comb begin
        hold_d = push_ok ? i_data : hold_q;
        full_d = full_q;
        if (push_ok)     full_d = 1'b1;
        else if (pop_ok) full_d = 1'b0;
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
        end
    end
`endif

endmodule

// File: rtl/uart_tx_stream.sv
// rtl/uart_tx_stream.sv - buffered UART transmitter with a valid/ready word input
//
// Words accepted on i_data_valid && o_data_ready are buffered in uart_tx_fifo
// and serialised as start / DATA_WIDTH data bits (LSB first) / optional parity
// / STOP_BITS stop bits. Build option UART_TX_STREAM_FIFO_EN selects a
// FIFO_DEPTH-deep buffer; without it a single holding register is used.
//
// Ports:
//   i_clk_sys, i_rst_n   clock, asynchronous active-low reset
//   i_data_tx            word to send
//   i_data_valid         word offered
//   o_data_ready         word accepted this cycle when valid
//   o_uart_tx_data       serial line, idle high
//   o_uart_tx_busy       FSM not idle
//   o_uart_tx_end        one-cycle pulse as the last stop bit completes
//   o_fifo_level         words buffered and not yet loaded
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int CLK_FRE     = 50,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          i_clk_sys,
    input  logic                          i_rst_n,
    input  logic [DATA_WIDTH-1:0]         i_data_tx,
    input  logic                          i_data_valid,
    output logic                          o_data_ready,
    output logic                          o_uart_tx_data,
    output logic                          o_uart_tx_busy,
    output logic                          o_uart_tx_end,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int CYCLE = calc_cycle(CLK_FRE, BAUD_RATE);
    localparam int CNT_W = (CYCLE > 1) ? $clog2(CYCLE) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYCLE - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    tx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic                  line_q, line_d;
    logic                  end_q, end_d;
    logic                  rdy_en_q, rdy_en_d;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  head_parity;
    logic                  bit_done;
    logic                  data_last;
    logic                  stop_last;

    // Held low through reset so ready only rises on the first clock after it.
    assign rdy_en_d       = 1'b1;
    assign o_data_ready   = rdy_en_q && !fifo_full;
    assign fifo_push      = i_data_valid && o_data_ready;
    assign o_uart_tx_data = line_q;
    assign o_uart_tx_busy = (state_q != ST_IDLE);
    assign o_uart_tx_end  = end_q;

    assign bit_done  = (baud_cnt_q == CNT_LAST);
    assign data_last = bit_done && (bit_cnt_q == DATA_LAST);
    assign stop_last = bit_done && (bit_cnt_q == STOP_LAST);

    uart_tx_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk_sys(i_clk_sys),
        .i_rst_n  (i_rst_n),
        .i_push   (fifo_push),
        .i_data   (i_data_tx),
        .i_pop    (fifo_pop),
        .o_data   (fifo_head),
        .o_empty  (fifo_empty),
        .o_full   (fifo_full),
        .o_level  (o_fifo_level)
    );

    always_comb begin
        if (PARITY_MODE == PAR_EVEN)      head_parity = ^fifo_head;
        else if (PARITY_MODE == PAR_ODD)  head_parity = ~^fifo_head;
        else if (PARITY_MODE == PAR_MARK) head_parity = 1'b1;
        else                              head_parity = 1'b0;
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!fifo_empty) state_d = ST_START;
            ST_START:  if (bit_done)    state_d = ST_DATA;
            ST_DATA:   if (data_last)   state_d = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_done)    state_d = ST_STOP;
            // Chain straight into the next start bit when a word is waiting.
            ST_STOP:   if (stop_last)   state_d = fifo_empty ? ST_IDLE : ST_START;
            default:                    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        baud_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        line_d     = 1'b1;
        end_d      = 1'b0;
        fifo_pop   = 1'b0;

        // Counters restart on every state change, including STOP -> START.
        if (state_d != state_q) begin
            bit_cnt_d = '0;
        end else if (state_q != ST_IDLE) begin
            baud_cnt_d = bit_done ? '0 : baud_cnt_q + CNT_W'(1);
            if (bit_done) bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end

        fifo_pop = !fifo_empty && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && stop_last));
        if (fifo_pop) begin
            shift_d  = fifo_head;
            parity_d = head_parity;
        end else if ((state_q == ST_DATA) && bit_done) begin
            shift_d = {1'b1, shift_q[DATA_WIDTH-1:1]};
        end

        // Line is registered from the current state, one clock behind it.
        case (state_q)
            ST_START:  line_d = 1'b0;
            ST_DATA:   line_d = shift_q[0];
            ST_PARITY: line_d = parity_q;
            default:   line_d = 1'b1;
        endcase

        end_d = (state_q == ST_STOP) && stop_last;
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            line_q     <= 1'b1;
            end_q      <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            line_q     <= line_d;
            end_q      <= end_d;
            rdy_en_q   <= rdy_en_d;
        end
    end

endmodule
